// File: rtl/ddr3_req_arbiter.sv
// Round-robin arbiter sharing the ddr3_fsm write/read request ports among PORTS requesters,
// with grant locking across multi-command bursts. Optional macro: DDR3_ARB_TID_TAG_EN.
module ddr3_req_arbiter #(
    parameter int PORTS       = 4,
    parameter int REQID       = 4,
    parameter int ADDRS       = 25,
    parameter int LOCK_CYCLES = 255,
    localparam int PSB        = $clog2(PORTS) - 1,
    localparam int TIDW       = REQID + PSB + 1
) (
    input  logic                   clock,
    input  logic                   reset,

    input  logic [PORTS-1:0]       req_req_i,
    input  logic [PORTS-1:0]       req_wr_i,
    input  logic [PORTS-1:0]       req_lst_i,
    input  logic [PORTS*REQID-1:0] req_tid_i,
    input  logic [PORTS*ADDRS-1:0] req_adr_i,
    output logic [PORTS-1:0]       req_ack_o,
    output logic [PORTS-1:0]       req_err_o,

    output logic                   fsm_wrreq_o,
    output logic                   fsm_wrlst_o,
    output logic [TIDW-1:0]        fsm_wrtid_o,
    output logic [ADDRS-1:0]       fsm_wradr_o,
    input  logic                   fsm_wrack_i,
    input  logic                   fsm_wrerr_i,

    output logic                   fsm_rdreq_o,
    output logic                   fsm_rdlst_o,
    output logic [TIDW-1:0]        fsm_rdtid_o,
    output logic [ADDRS-1:0]       fsm_rdadr_o,
    input  logic                   fsm_rdack_i,
    input  logic                   fsm_rderr_i,

    output logic [PORTS-1:0]       arb_gnt_o,
    output logic                   arb_lck_o,
    output logic                   arb_tmo_o
);

    localparam int PW = PSB + 1;

    // Handshake: a requester holds req_req_i with stable fields until it sees its req_ack_o
    // bit; req_err_o is only meaningful while req_ack_o is high. The FSM side follows the
    // same rule: fsm_*req_o stays high with stable fields until fsm_*ack_i is sampled.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2,
        S_LOCK  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    gnt_q;
    logic             wr_q;
    logic             lst_q;
    logic [REQID-1:0] tid_q;
    logic [ADDRS-1:0] adr_q;
    logic [7:0]       lock_cnt_q;

    logic             pick_vld;
    logic [PW-1:0]    pick_idx;
    logic             load_cmd;
    logic [PW-1:0]    load_idx;
    logic             release_grant;
    logic             lock_timeout;
    logic             ack_in;
    logic             err_in;
    logic             ack_hit;
    logic [PW-1:0]    next_ptr;

    // First requesting port at or after the round-robin pointer, wrapping modulo PORTS.
    always_comb begin
        int j;
        j        = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < PORTS; i++) begin
            j = int'(ptr_q) + i;
            if (j >= PORTS) begin
                j = j - PORTS;
            end
            if (!pick_vld && req_req_i[j]) begin
                pick_vld = 1'b1;
                pick_idx = PW'(j);
            end
        end
    end

    assign ack_in   = wr_q ? fsm_wrack_i : fsm_rdack_i;
    assign err_in   = wr_q ? fsm_wrerr_i : fsm_rderr_i;
    // Reset abandons an in-flight command, so an ack seen in the reset cycle is not forwarded.
    assign ack_hit  = (state_q == S_ISSUE) && ack_in && !reset;
    assign next_ptr = (gnt_q == PW'(PORTS - 1)) ? '0 : gnt_q + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        load_cmd      = 1'b0;
        load_idx      = pick_idx;
        release_grant = 1'b0;
        lock_timeout  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    load_cmd = 1'b1;
                    load_idx = pick_idx;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ack_hit) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (lst_q) begin
                    release_grant = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    state_d = S_LOCK;
                end
            end
            S_LOCK: begin
                if (req_req_i[gnt_q]) begin
                    load_cmd = 1'b1;
                    load_idx = gnt_q;
                    state_d  = S_ISSUE;
                end else if (lock_cnt_q == 8'(LOCK_CYCLES - 1)) begin
                    lock_timeout  = 1'b1;
                    release_grant = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q      <= '0;
            gnt_q      <= '0;
            wr_q       <= 1'b0;
            lst_q      <= 1'b0;
            tid_q      <= '0;
            adr_q      <= '0;
            lock_cnt_q <= '0;
        end else begin
            if (load_cmd) begin
                gnt_q <= load_idx;
                wr_q  <= req_wr_i[load_idx];
                lst_q <= req_lst_i[load_idx];
                tid_q <= req_tid_i[int'(load_idx)*REQID +: REQID];
                adr_q <= req_adr_i[int'(load_idx)*ADDRS +: ADDRS];
            end
            if (release_grant) begin
                ptr_q <= next_ptr;
            end
            // Counts idle LOCK cycles; any exit from LOCK clears it.
            if (state_q == S_LOCK && state_d == S_LOCK) begin
                lock_cnt_q <= lock_cnt_q + 8'd1;
            end else begin
                lock_cnt_q <= '0;
            end
        end
    end

    always_comb begin
        arb_gnt_o = '0;
        if (state_q != S_IDLE) begin
            arb_gnt_o[gnt_q] = 1'b1;
        end
        req_ack_o = '0;
        req_err_o = '0;
        if (ack_hit) begin
            req_ack_o[gnt_q] = 1'b1;
            req_err_o[gnt_q] = err_in;
        end
        fsm_wrreq_o = (state_q == S_ISSUE) && wr_q;
        fsm_rdreq_o = (state_q == S_ISSUE) && !wr_q;
        arb_lck_o   = (state_q == S_LOCK);
        arb_tmo_o   = lock_timeout;
    end

    assign fsm_wrlst_o = lst_q;
    assign fsm_rdlst_o = lst_q;
    assign fsm_wradr_o = adr_q;
    assign fsm_rdadr_o = adr_q;

`ifdef DDR3_ARB_TID_TAG_EN
    assign fsm_wrtid_o = {gnt_q, tid_q};
    assign fsm_rdtid_o = {gnt_q, tid_q};
`else
    assign fsm_wrtid_o = {{PW{1'b0}}, tid_q};
    assign fsm_rdtid_o = {{PW{1'b0}}, tid_q};
`endif

    // Structural invariants of the grant and request outputs.
    a_one_dir : assert property (@(posedge clock) disable iff (reset) !(fsm_wrreq_o && fsm_rdreq_o));
    a_gnt_oh  : assert property (@(posedge clock) disable iff (reset) $onehot0(arb_gnt_o));

endmodule

// File: tb/tb_ddr3_req_arbiter.sv
// Directed bench for ddr3_req_arbiter: reset, round-robin order, burst locking, lock timeout,
// ID tagging and error return.
module tb_ddr3_req_arbiter;

    localparam int PORTS = 4;
    localparam int REQID = 4;
    localparam int ADDRS = 25;
    localparam int TIDW  = 6;

    logic                   clock;
    logic                   reset;
    logic [PORTS-1:0]       req_req;
    logic [PORTS-1:0]       req_wr;
    logic [PORTS-1:0]       req_lst;
    logic [PORTS*REQID-1:0] req_tid;
    logic [PORTS*ADDRS-1:0] req_adr;
    logic [PORTS-1:0]       req_ack;
    logic [PORTS-1:0]       req_err;
    logic                   fsm_wrreq, fsm_wrlst, fsm_wrack, fsm_wrerr;
    logic [TIDW-1:0]        fsm_wrtid;
    logic [ADDRS-1:0]       fsm_wradr;
    logic                   fsm_rdreq, fsm_rdlst, fsm_rdack, fsm_rderr;
    logic [TIDW-1:0]        fsm_rdtid;
    logic [ADDRS-1:0]       fsm_rdadr;
    logic [PORTS-1:0]       arb_gnt;
    logic                   arb_lck;
    logic                   arb_tmo;

    int checks   = 0;
    int failures = 0;

    ddr3_req_arbiter #(.PORTS(PORTS), .REQID(REQID), .ADDRS(ADDRS), .LOCK_CYCLES(8)) dut (
        .clock(clock), .reset(reset),
        .req_req_i(req_req), .req_wr_i(req_wr), .req_lst_i(req_lst),
        .req_tid_i(req_tid), .req_adr_i(req_adr),
        .req_ack_o(req_ack), .req_err_o(req_err),
        .fsm_wrreq_o(fsm_wrreq), .fsm_wrlst_o(fsm_wrlst), .fsm_wrtid_o(fsm_wrtid),
        .fsm_wradr_o(fsm_wradr), .fsm_wrack_i(fsm_wrack), .fsm_wrerr_i(fsm_wrerr),
        .fsm_rdreq_o(fsm_rdreq), .fsm_rdlst_o(fsm_rdlst), .fsm_rdtid_o(fsm_rdtid),
        .fsm_rdadr_o(fsm_rdadr), .fsm_rdack_i(fsm_rdack), .fsm_rderr_i(fsm_rderr),
        .arb_gnt_o(arb_gnt), .arb_lck_o(arb_lck), .arb_tmo_o(arb_tmo)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // driver tasks
    task automatic clear_inputs();
        req_req = '0; req_wr = '0; req_lst = '0; req_tid = '0; req_adr = '0;
        fsm_wrack = 1'b0; fsm_wrerr = 1'b0; fsm_rdack = 1'b0; fsm_rderr = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic set_cmd(input int p, input logic wr, input logic lst,
                           input logic [REQID-1:0] tid, input logic [ADDRS-1:0] adr);
        req_req[p] = 1'b1;
        req_wr[p]  = wr;
        req_lst[p] = lst;
        req_tid[p*REQID +: REQID] = tid;
        req_adr[p*ADDRS +: ADDRS] = adr;
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic test_reset();
        step(); #1;
        checks++; if (arb_gnt !== 4'b0000) begin failures++; $display("FAIL rst_gnt got=%b exp=0000", arb_gnt); end
        checks++; if ({fsm_wrreq, fsm_rdreq, arb_lck, arb_tmo} !== 4'b0000) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {fsm_wrreq, fsm_rdreq, arb_lck, arb_tmo}); end
        checks++; if ({fsm_wrtid, fsm_rdtid, fsm_wradr, fsm_wrlst} !== '0) begin failures++; $display("FAIL rst_fields got=%h/%h/%h exp=0", fsm_wrtid, fsm_rdtid, fsm_wradr); end
        reset = 1'b0;
        // acks outside ISSUE must not reach any requester
        step(); fsm_wrack = 1'b1; fsm_rdack = 1'b1; fsm_rderr = 1'b1; #1;
        checks++; if ({req_ack, req_err} !== 8'h00) begin failures++; $display("FAIL idle_ack got=%b_%b exp=0000_0000", req_ack, req_err); end
        step(); clear_inputs(); #1;
        checks++; if ({fsm_wrreq, fsm_rdreq, arb_gnt} !== 6'b0) begin failures++; $display("FAIL idle_ack_state got=%b exp=0", {fsm_wrreq, fsm_rdreq, arb_gnt}); end
    endtask

    task automatic test_single_write();
        apply_reset();
        step(); set_cmd(0, 1'b1, 1'b1, 4'd1, 25'd16); #1;
        checks++; if (fsm_wrreq !== 1'b0) begin failures++; $display("FAIL t1_lat0 got=%b exp=0", fsm_wrreq); end
        step(); #1;
        checks++; if ({fsm_wrreq, fsm_rdreq} !== 2'b10) begin failures++; $display("FAIL t1_req got=%b exp=10", {fsm_wrreq, fsm_rdreq}); end
        checks++; if (fsm_wradr !== 25'd16) begin failures++; $display("FAIL t1_adr got=%0d exp=16", fsm_wradr); end
        checks++; if ({fsm_wrtid, fsm_wrlst} !== {6'h01, 1'b1}) begin failures++; $display("FAIL t1_tid_lst got=%h/%b exp=01/1", fsm_wrtid, fsm_wrlst); end
        checks++; if (arb_gnt !== 4'b0001) begin failures++; $display("FAIL t1_gnt got=%b exp=0001", arb_gnt); end
        fsm_wrack = 1'b1; #1;
        checks++; if ({req_ack, req_err} !== 8'b0001_0000) begin failures++; $display("FAIL t1_ack got=%b_%b exp=0001_0000", req_ack, req_err); end
        step(); fsm_wrack = 1'b0; req_req[0] = 1'b0; #1;
        checks++; if ({fsm_wrreq, arb_gnt, req_ack} !== 9'b0_0001_0000) begin failures++; $display("FAIL t1_hold got=%b exp=000010000", {fsm_wrreq, arb_gnt, req_ack}); end
        step(); #1;
        checks++; if (arb_gnt !== 4'b0000) begin failures++; $display("FAIL t1_idle_gnt got=%b exp=0000", arb_gnt); end
        // pointer moved to 1: port1 beats port0
        set_cmd(0, 1'b0, 1'b1, 4'd2, 25'd100);
        set_cmd(1, 1'b0, 1'b1, 4'd3, 25'd200);
        step(); #1;
        checks++; if ({arb_gnt, fsm_rdreq, fsm_wrreq} !== 6'b0010_10) begin failures++; $display("FAIL t1_ptr got=%b exp=001010", {arb_gnt, fsm_rdreq, fsm_wrreq}); end
        checks++; if (fsm_rdadr !== 25'd200) begin failures++; $display("FAIL t1_ptr_adr got=%0d exp=200", fsm_rdadr); end
        fsm_rdack = 1'b1; #1;
        checks++; if (req_ack !== 4'b0010) begin failures++; $display("FAIL t1_ptr_ack got=%b exp=0010", req_ack); end
        step(); clear_inputs();
        step();
    endtask

    task automatic test_simultaneous();
        apply_reset();
        step(); set_cmd(0, 1'b0, 1'b1, 4'd4, 25'd40); set_cmd(2, 1'b0, 1'b1, 4'd6, 25'd42);
        step(); #1;
        checks++; if ({arb_gnt, fsm_rdreq} !== 5'b0001_1) begin failures++; $display("FAIL t2_first got=%b exp=00011", {arb_gnt, fsm_rdreq}); end
        checks++; if (fsm_rdadr !== 25'd40) begin failures++; $display("FAIL t2_first_adr got=%0d exp=40", fsm_rdadr); end
        fsm_rdack = 1'b1; #1;
        checks++; if (req_ack !== 4'b0001) begin failures++; $display("FAIL t2_ack0 got=%b exp=0001", req_ack); end
        step(); fsm_rdack = 1'b0; req_req[0] = 1'b0; #1;
        checks++; if (fsm_rdreq !== 1'b0) begin failures++; $display("FAIL t2_e1 got=%b exp=0", fsm_rdreq); end
        step(); #1;
        checks++; if ({fsm_rdreq, arb_gnt} !== 5'b0_0000) begin failures++; $display("FAIL t2_e2 got=%b exp=00000", {fsm_rdreq, arb_gnt}); end
        step(); #1;
        checks++; if ({arb_gnt, fsm_rdreq} !== 5'b0100_1) begin failures++; $display("FAIL t2_second got=%b exp=01001", {arb_gnt, fsm_rdreq}); end
        checks++; if (fsm_rdadr !== 25'd42) begin failures++; $display("FAIL t2_second_adr got=%0d exp=42", fsm_rdadr); end
        fsm_rdack = 1'b1; #1;
        checks++; if (req_ack !== 4'b0100) begin failures++; $display("FAIL t2_ack2 got=%b exp=0100", req_ack); end
        step(); clear_inputs();
        step();
    endtask

    task automatic test_lock_burst();
        apply_reset();
        step(); set_cmd(1, 1'b1, 1'b0, 4'd7, 25'd0);
        step(); set_cmd(0, 1'b0, 1'b1, 4'd8, 25'd77); #1;
        checks++; if ({arb_gnt, fsm_wrreq, fsm_wrlst} !== 6'b0010_10) begin failures++; $display("FAIL t3_cmd1 got=%b exp=001010", {arb_gnt, fsm_wrreq, fsm_wrlst}); end
        fsm_wrack = 1'b1; #1;
        checks++; if (req_ack !== 4'b0010) begin failures++; $display("FAIL t3_ack1 got=%b exp=0010", req_ack); end
        step(); fsm_wrack = 1'b0; req_req[1] = 1'b0; #1;
        checks++; if ({arb_gnt, arb_lck} !== 5'b0010_0) begin failures++; $display("FAIL t3_hold got=%b exp=00100", {arb_gnt, arb_lck}); end
        step(); #1;
        checks++; if ({arb_gnt, arb_lck, fsm_rdreq, fsm_wrreq} !== 7'b0010_1_00) begin failures++; $display("FAIL t3_lock got=%b exp=0010100", {arb_gnt, arb_lck, fsm_rdreq, fsm_wrreq}); end
        set_cmd(1, 1'b1, 1'b1, 4'd7, 25'd8);
        step(); #1;
        checks++; if ({arb_gnt, fsm_wrreq, fsm_rdreq, fsm_wrlst, arb_lck} !== 8'b0010_1010) begin failures++; $display("FAIL t3_cmd2 got=%b exp=00101010", {arb_gnt, fsm_wrreq, fsm_rdreq, fsm_wrlst, arb_lck}); end
        checks++; if (fsm_wradr !== 25'd8) begin failures++; $display("FAIL t3_cmd2_adr got=%0d exp=8", fsm_wradr); end
        fsm_wrack = 1'b1; #1;
        checks++; if (req_ack !== 4'b0010) begin failures++; $display("FAIL t3_ack2 got=%b exp=0010", req_ack); end
        step(); fsm_wrack = 1'b0; req_req[1] = 1'b0;
        step(); #1;
        checks++; if ({arb_gnt, arb_lck} !== 5'b0000_0) begin failures++; $display("FAIL t3_release got=%b exp=00000", {arb_gnt, arb_lck}); end
        step(); #1;
        checks++; if ({arb_gnt, fsm_rdreq} !== 5'b0001_1) begin failures++; $display("FAIL t3_port0 got=%b exp=00011", {arb_gnt, fsm_rdreq}); end
        fsm_rdack = 1'b1;
        step(); clear_inputs();
        step();
    endtask

    task automatic test_wrap();
        apply_reset();
        step(); set_cmd(3, 1'b1, 1'b1, 4'd9, 25'd300);
        step(); #1;
        checks++; if (arb_gnt !== 4'b1000) begin failures++; $display("FAIL t4_p3 got=%b exp=1000", arb_gnt); end
        fsm_wrack = 1'b1; #1;
        checks++; if (req_ack !== 4'b1000) begin failures++; $display("FAIL t4_ack3 got=%b exp=1000", req_ack); end
        step(); fsm_wrack = 1'b0; req_req[3] = 1'b0;
        step(); set_cmd(0, 1'b0, 1'b1, 4'd1, 25'd1); set_cmd(3, 1'b0, 1'b1, 4'd2, 25'd2);
        step(); #1;
        checks++; if ({arb_gnt, fsm_rdreq} !== 5'b0001_1) begin failures++; $display("FAIL t4_wrap got=%b exp=00011", {arb_gnt, fsm_rdreq}); end
        fsm_rdack = 1'b1;
        step(); clear_inputs();
        step();
    endtask

    task automatic test_lock_timeout();
        apply_reset();
        step(); set_cmd(2, 1'b1, 1'b0, 4'd3, 25'd500);
        step(); fsm_wrack = 1'b1; #1;
        checks++; if (req_ack !== 4'b0100) begin failures++; $display("FAIL t5_ack got=%b exp=0100", req_ack); end
        step(); fsm_wrack = 1'b0; req_req[2] = 1'b0; set_cmd(1, 1'b0, 1'b1, 4'd4, 25'd600);
        for (int k = 1; k <= 7; k++) begin
            step(); #1;
            checks++; if ({arb_lck, arb_tmo, arb_gnt, fsm_rdreq} !== 7'b1_0_0100_0) begin failures++; $display("FAIL t5_lock%0d got=%b exp=1001000", k, {arb_lck, arb_tmo, arb_gnt, fsm_rdreq}); end
        end
        step(); #1;
        checks++; if ({arb_lck, arb_tmo} !== 2'b11) begin failures++; $display("FAIL t5_tmo got=%b exp=11", {arb_lck, arb_tmo}); end
        step(); #1;
        checks++; if ({arb_lck, arb_tmo, arb_gnt} !== 6'b0) begin failures++; $display("FAIL t5_after got=%b exp=000000", {arb_lck, arb_tmo, arb_gnt}); end
        step(); #1;
        checks++; if ({arb_gnt, fsm_rdreq} !== 5'b0010_1) begin failures++; $display("FAIL t5_port1 got=%b exp=00101", {arb_gnt, fsm_rdreq}); end
        fsm_rdack = 1'b1;
        step(); clear_inputs();
        step();
    endtask

    task automatic test_tid_err();
        logic [TIDW-1:0] exp_tid;
`ifdef DDR3_ARB_TID_TAG_EN
        exp_tid = {2'd2, 4'd5};
`else
        exp_tid = {2'd0, 4'd5};
`endif
        apply_reset();
        step(); set_cmd(2, 1'b0, 1'b1, 4'd5, 25'd1234);
        step(); fsm_wrack = 1'b1; #1;
        checks++; if (fsm_rdtid !== exp_tid) begin failures++; $display("FAIL t6_tid got=%h exp=%h", fsm_rdtid, exp_tid); end
        checks++; if (req_ack !== 4'b0000) begin failures++; $display("FAIL t6_wrong_dir got=%b exp=0000", req_ack); end
        step(); fsm_wrack = 1'b0; #1;
        checks++; if ({fsm_rdreq, arb_gnt} !== 5'b1_0100) begin failures++; $display("FAIL t6_still got=%b exp=10100", {fsm_rdreq, arb_gnt}); end
        fsm_rdack = 1'b1; fsm_rderr = 1'b1; #1;
        checks++; if ({req_ack, req_err} !== 8'b0100_0100) begin failures++; $display("FAIL t6_err got=%b_%b exp=0100_0100", req_ack, req_err); end
        step(); clear_inputs();
        step();
    endtask

    task automatic test_reset_mid_cmd();
        apply_reset();
        step(); set_cmd(0, 1'b1, 1'b1, 4'd1, 25'd9);
        step(); #1;
        checks++; if (fsm_wrreq !== 1'b1) begin failures++; $display("FAIL rm_issue got=%b exp=1", fsm_wrreq); end
        reset = 1'b1; fsm_wrack = 1'b1; #1;
        checks++; if (req_ack !== 4'b0000) begin failures++; $display("FAIL rm_ack got=%b exp=0000", req_ack); end
        step(); #1;
        checks++; if ({fsm_wrreq, arb_gnt, req_ack} !== 9'b0) begin failures++; $display("FAIL rm_after got=%b exp=0", {fsm_wrreq, arb_gnt, req_ack}); end
        reset = 1'b0; clear_inputs();
        step();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_write();
        test_simultaneous();
        test_lock_burst();
        test_wrap();
        test_lock_timeout();
        test_tid_err();
        test_reset_mid_cmd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
